vram_arbiter: RTL

Single-port VRAM arbiter for the HDMI text controller. It shares one 32-bit block-RAM port between two requesters, both in the pixel_clk domain:
- the video glyph-fetch path, which has fixed-latency, highest-priority reads;
- the host register path, which is the AXI-side adapter issuing reads and byte-masked writes through a request/acknowledge handshake.

The arbiter sits between the AXI slave logic and the VRAM block, alongside the VGA timing generator.

---
 rtl/hdmi_text_pkg.sv | 22 ++
 rtl/vram_arb_host_fsm.sv | 115 +++++++++++
 rtl/vram_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/hdmi_text_pkg.sv
// rtl/hdmi_text_pkg.sv - shared constants and types for the HDMI text controller
package hdmi_text_pkg;

   localparam int VRAM_WORDS     = 600;
   localparam int CTRL_INDEX     = 600;
   localparam int COLS           = 80;
   localparam int ROWS           = 30;
   localparam int CHARS_PER_WORD = 4;

   typedef logic [9:0]  vram_addr_t;
   typedef logic [31:0] vram_word_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ISSUE,
      RDWAIT,
      ACK,
      HOLD
   } host_state_t;

endpackage

// File: rtl/vram_arb_host_fsm.sv
// rtl/vram_arb_host_fsm.sv - host request/ack FSM and saturating grant-wait statistic
module vram_arb_host_fsm
   import hdmi_text_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = VRAM_WORDS,
   parameter int WAIT_W    = 8
) (
   input  logic              pixel_clk,
   input  logic              arstn,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              host_gnt,
   output logic              gnt_req,
   output logic              addr_ok,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic [WAIT_W-1:0] host_wait_max
);

   host_state_t       state_d, state_q;
   logic              err_d, err_q;
   logic              we_d, we_q;
   logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
   logic [WAIT_W-1:0] wait_max_d, wait_max_q;
   logic              ack_d, ack_q;
   logic              herr_d, herr_q;
   logic [DATA_W-1:0] rdata_d, rdata_q;

   assign gnt_req = (state_q == REQ);
   assign addr_ok = 32'(host_addr) < 32'(NUM_WORDS);

   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      we_d       = we_q;
      wait_cnt_d = wait_cnt_q;
      wait_max_d = wait_max_q;
      ack_d      = 1'b0;
      herr_d     = 1'b0;
      rdata_d    = rdata_q;
      case (state_q)
         IDLE: begin
            if (host_req) begin
               state_d    = REQ;
               wait_cnt_d = '0;
            end
         end
         REQ: begin
            if (host_gnt) begin
               state_d = ISSUE;
               err_d   = ~addr_ok;
               we_d    = host_we;
               if (wait_cnt_q > wait_max_q) wait_max_d = wait_cnt_q;
            end else if (wait_cnt_q != {WAIT_W{1'b1}}) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ISSUE: begin
            // out-of-range requests never touched the RAM; answer them directly
            if (err_q) begin
               state_d = ACK;
               ack_d   = 1'b1;
               herr_d  = 1'b1;
               rdata_d = '0;
            end else if (we_q) begin
               state_d = ACK;
               ack_d   = 1'b1;
            end else begin
               state_d = RDWAIT;
            end
         end
         RDWAIT: begin
            state_d = ACK;
            ack_d   = 1'b1;
            rdata_d = ram_rdata;
         end
         ACK:     state_d = HOLD;
         HOLD:    if (!host_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (!arstn) begin
         state_q    <= IDLE;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         wait_cnt_q <= '0;
         wait_max_q <= '0;
         ack_q      <= 1'b0;
         herr_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         we_q       <= we_d;
         wait_cnt_q <= wait_cnt_d;
         wait_max_q <= wait_max_d;
         ack_q      <= ack_d;
         herr_q     <= herr_d;
         rdata_q    <= rdata_d;
      end
   end

   assign host_ack      = ack_q;
   assign host_err      = herr_q;
   assign host_rdata    = rdata_q;
   assign host_wait_max = wait_max_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: fixed-latency video reads over host register access
module vram_arbiter
   import hdmi_text_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = VRAM_WORDS,
   parameter int WAIT_W    = 8
) (
   input  logic              pixel_clk,
   input  logic              arstn,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [3:0]        host_be,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_err,
   output logic [WAIT_W-1:0] host_wait_max,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic              gnt_req, addr_ok, host_gnt, host_ram, host_wr;
   logic              ram_en_d, ram_en_q;
   logic [3:0]        ram_we_d, ram_we_q;
   logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_d, ram_wdata_q;
   logic              vid_p1_d, vid_p1_q, vid_p2_d, vid_p2_q;
   logic              vid_valid_d, vid_valid_q;
   logic [DATA_W-1:0] vid_data_d, vid_data_q;

   vram_arb_host_fsm #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS),
      .WAIT_W    (WAIT_W)
   ) u_host_fsm (
      .pixel_clk     (pixel_clk),
      .arstn         (arstn),
      .host_req      (host_req),
      .host_we       (host_we),
      .host_addr     (host_addr),
      .ram_rdata     (ram_rdata),
      .host_gnt      (host_gnt),
      .gnt_req       (gnt_req),
      .addr_ok       (addr_ok),
      .host_ack      (host_ack),
      .host_rdata    (host_rdata),
      .host_err      (host_err),
      .host_wait_max (host_wait_max)
   );

   // video always owns the slot; the host only gets cycles video leaves idle
   assign host_gnt = gnt_req & ~vid_req;
   assign host_ram = host_gnt & addr_ok;
   assign host_wr  = host_ram & host_we;

   always_comb begin
      ram_en_d    = vid_req | host_ram;
      ram_we_d    = host_wr ? host_be : 4'b0000;
      ram_wdata_d = host_wr ? host_wdata : '0;
      ram_addr_d  = '0;
      if (vid_req)       ram_addr_d = vid_addr;
      else if (host_ram) ram_addr_d = host_addr;
      vid_p1_d    = vid_req;
      vid_p2_d    = vid_p1_q;
      vid_valid_d = vid_p2_q;
      vid_data_d  = vid_p2_q ? ram_rdata : vid_data_q;
   end

   always_ff @(posedge pixel_clk) begin
      if (!arstn) begin
         ram_en_q    <= 1'b0;
         ram_we_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         vid_p1_q    <= 1'b0;
         vid_p2_q    <= 1'b0;
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
      end else begin
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         vid_p1_q    <= vid_p1_d;
         vid_p2_q    <= vid_p2_d;
         vid_valid_q <= vid_valid_d;
         vid_data_q  <= vid_data_d;
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign vid_valid = vid_valid_q;
   assign vid_data  = vid_data_q;

endmodule
